// File: rtl/vc_input_unit.sv
// vc_input_unit: per-VC flit buffering and packet state tracking for one router input port.
// Each VC owns a FIFO and walks IDLE -> ROUTING -> WAITING -> ACTIVE (<-> CREDITS) per packet.
module vc_input_unit #(
  parameter int FLIT_SIZE = 32,
  parameter int NUM_VC    = 4,
  parameter int VC_DEPTH  = 8,
  parameter int OVC_W     = 2,
  localparam int VCW      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int PW       = $clog2(VC_DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [FLIT_SIZE-1:0]        flit_in,
  input  logic                        valid_in,
  input  logic [VCW-1:0]              vc_in,
  input  logic                        route_ack_valid,
  input  logic [VCW-1:0]              route_ack_vc,
  input  logic [2:0]                  route_ack_port,
  input  logic                        va_grant_valid,
  input  logic [VCW-1:0]              va_grant_vc,
  input  logic [OVC_W-1:0]            va_grant_ovc,
  input  logic [NUM_VC-1:0]           credit_ok,
  input  logic [NUM_VC-1:0]           sw_grant,
  output logic [NUM_VC*FLIT_SIZE-1:0] head_flat,
  output logic [NUM_VC-1:0]           route_req,
  output logic [NUM_VC-1:0]           va_req,
  output logic [NUM_VC-1:0]           sw_req,
  output logic [FLIT_SIZE-1:0]        flit_out,
  output logic                        flit_out_valid,
  output logic [2:0]                  flit_out_port,
  output logic [OVC_W-1:0]            flit_out_ovc,
  output logic                        credit_out_valid,
  output logic [VCW-1:0]              credit_out_vc,
  output logic [NUM_VC*3-1:0]         G_flat,
  output logic [NUM_VC*3-1:0]         R_flat,
  output logic [NUM_VC*OVC_W-1:0]     O_flat,
  output logic [NUM_VC*PW-1:0]        P_flat,
  output logic                        err
);

  localparam int AW = $clog2(VC_DEPTH);

  localparam logic [1:0] FT_HEAD   = 2'b00;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  typedef enum logic [2:0] {
    G_IDLE    = 3'd0,
    G_ROUTING = 3'd1,
    G_WAITING = 3'd2,
    G_ACTIVE  = 3'd3,
    G_CREDITS = 3'd4
  } vc_state_e;

  logic [FLIT_SIZE-1:0] mem_q    [NUM_VC][VC_DEPTH];
  logic [FLIT_SIZE-1:0] mem_d    [NUM_VC][VC_DEPTH];
  logic [AW-1:0]        rd_ptr_q [NUM_VC];
  logic [AW-1:0]        rd_ptr_d [NUM_VC];
  logic [AW-1:0]        wr_ptr_q [NUM_VC];
  logic [AW-1:0]        wr_ptr_d [NUM_VC];
  logic [PW-1:0]        count_q  [NUM_VC];
  logic [PW-1:0]        count_d  [NUM_VC];
  vc_state_e            state_q  [NUM_VC];
  vc_state_e            state_d  [NUM_VC];
  logic [2:0]           route_q  [NUM_VC];
  logic [2:0]           route_d  [NUM_VC];
  logic [OVC_W-1:0]     ovc_q    [NUM_VC];
  logic [OVC_W-1:0]     ovc_d    [NUM_VC];

  logic [FLIT_SIZE-1:0] flit_out_q, flit_out_d;
  logic                 flit_out_valid_q, flit_out_valid_d;
  logic [2:0]           flit_out_port_q, flit_out_port_d;
  logic [OVC_W-1:0]     flit_out_ovc_q, flit_out_ovc_d;
  logic                 credit_out_valid_q, credit_out_valid_d;
  logic [VCW-1:0]       credit_out_vc_q, credit_out_vc_d;
  logic                 err_q, err_d;

  logic [FLIT_SIZE-1:0] front [NUM_VC];
  logic [1:0]           front_type [NUM_VC];
  logic [NUM_VC-1:0]    empty;
  logic [NUM_VC-1:0]    full;
  logic [NUM_VC-1:0]    wr_en;
  logic [NUM_VC-1:0]    deq;
  logic                 win_valid;
  logic [VCW-1:0]       win_vc;

  // FIFO status, request outputs and the flattened per-VC views, all straight from the registers.
  always_comb begin
    head_flat = '0;
    G_flat    = '0;
    R_flat    = '0;
    O_flat    = '0;
    P_flat    = '0;
    route_req = '0;
    va_req    = '0;
    sw_req    = '0;
    empty     = '0;
    full      = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      front[v]      = mem_q[v][rd_ptr_q[v]];
      front_type[v] = front[v][FLIT_SIZE-1 -: 2];
      empty[v]      = (count_q[v] == '0);
      full[v]       = (count_q[v] == PW'(VC_DEPTH));
      route_req[v]  = (state_q[v] == G_ROUTING);
      va_req[v]     = (state_q[v] == G_WAITING);
      sw_req[v]     = (state_q[v] == G_ACTIVE) && !empty[v] && credit_ok[v];
      head_flat[v*FLIT_SIZE +: FLIT_SIZE] = front[v];
      G_flat[v*3 +: 3]         = state_q[v];
      R_flat[v*3 +: 3]         = route_q[v];
      O_flat[v*OVC_W +: OVC_W] = ovc_q[v];
      P_flat[v*PW +: PW]       = PW'(VC_DEPTH) - count_q[v];
    end
  end

  // Fixed-priority switch winner: lowest VC that both requests and is granted.
  always_comb begin
    win_valid = 1'b0;
    win_vc    = '0;
    for (int v = NUM_VC - 1; v >= 0; v--) begin
      if (sw_req[v] && sw_grant[v]) begin
        win_valid = 1'b1;
        win_vc    = VCW'(v);
      end
    end
  end

  // Per-VC state transitions, FIFO write/dequeue bookkeeping and the registered output flit.
  always_comb begin
    mem_d              = mem_q;
    rd_ptr_d           = rd_ptr_q;
    wr_ptr_d           = wr_ptr_q;
    count_d            = count_q;
    state_d            = state_q;
    route_d            = route_q;
    ovc_d              = ovc_q;
    err_d              = err_q;
    flit_out_d         = flit_out_q;
    flit_out_port_d    = flit_out_port_q;
    flit_out_ovc_d     = flit_out_ovc_q;
    credit_out_vc_d    = credit_out_vc_q;
    flit_out_valid_d   = 1'b0;
    credit_out_valid_d = 1'b0;
    wr_en              = '0;
    deq                = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      case (state_q[v])
        G_IDLE: begin
          if (!empty[v]) begin
            if (front_type[v] == FT_HEAD || front_type[v] == FT_SINGLE) begin
              state_d[v] = G_ROUTING;
            end else begin
              deq[v] = 1'b1;
              err_d  = 1'b1;
            end
          end
        end
        G_ROUTING: begin
          if (route_ack_valid && route_ack_vc == VCW'(v)) begin
            route_d[v] = route_ack_port;
            state_d[v] = G_WAITING;
          end
        end
        G_WAITING: begin
          if (va_grant_valid && va_grant_vc == VCW'(v)) begin
            ovc_d[v]   = va_grant_ovc;
            state_d[v] = G_ACTIVE;
          end
        end
        G_ACTIVE: begin
          if (win_valid && win_vc == VCW'(v)) begin
            deq[v]             = 1'b1;
            flit_out_d         = front[v];
            flit_out_valid_d   = 1'b1;
            flit_out_port_d    = route_q[v];
            flit_out_ovc_d     = ovc_q[v];
            credit_out_valid_d = 1'b1;
            credit_out_vc_d    = VCW'(v);
            if (front_type[v] == FT_TAIL || front_type[v] == FT_SINGLE) begin
              state_d[v] = G_IDLE;
              route_d[v] = '0;
              ovc_d[v]   = '0;
            end
          end else if (!empty[v] && !credit_ok[v]) begin
            state_d[v] = G_CREDITS;
          end
        end
        G_CREDITS: begin
          if (credit_ok[v]) begin
            state_d[v] = G_ACTIVE;
          end
        end
        default: begin
          state_d[v] = G_IDLE;
        end
      endcase

      if (valid_in && vc_in == VCW'(v)) begin
        if (full[v]) begin
          err_d = 1'b1;
        end else begin
          wr_en[v] = 1'b1;
          mem_d[v][wr_ptr_q[v]] = flit_in;
          wr_ptr_d[v] = wr_ptr_q[v] + AW'(1);
        end
      end

      if (deq[v]) begin
        rd_ptr_d[v] = rd_ptr_q[v] + AW'(1);
      end

      case ({wr_en[v], deq[v]})
        2'b10:   count_d[v] = count_q[v] + PW'(1);
        2'b01:   count_d[v] = count_q[v] - PW'(1);
        default: count_d[v] = count_q[v];
      endcase
    end
  end

  // Control and output registers; reset empties every FIFO and idles every VC at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        rd_ptr_q[v] <= '0;
        wr_ptr_q[v] <= '0;
        count_q[v]  <= '0;
        state_q[v]  <= G_IDLE;
        route_q[v]  <= '0;
        ovc_q[v]    <= '0;
      end
      flit_out_q         <= '0;
      flit_out_valid_q   <= 1'b0;
      flit_out_port_q    <= '0;
      flit_out_ovc_q     <= '0;
      credit_out_valid_q <= 1'b0;
      credit_out_vc_q    <= '0;
      err_q              <= 1'b0;
    end else begin
      rd_ptr_q           <= rd_ptr_d;
      wr_ptr_q           <= wr_ptr_d;
      count_q            <= count_d;
      state_q            <= state_d;
      route_q            <= route_d;
      ovc_q              <= ovc_d;
      flit_out_q         <= flit_out_d;
      flit_out_valid_q   <= flit_out_valid_d;
      flit_out_port_q    <= flit_out_port_d;
      flit_out_ovc_q     <= flit_out_ovc_d;
      credit_out_valid_q <= credit_out_valid_d;
      credit_out_vc_q    <= credit_out_vc_d;
      err_q              <= err_d;
    end
  end

  // FIFO storage; contents need no reset because the counts and pointers define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign flit_out         = flit_out_q;
  assign flit_out_valid   = flit_out_valid_q;
  assign flit_out_port    = flit_out_port_q;
  assign flit_out_ovc     = flit_out_ovc_q;
  assign credit_out_valid = credit_out_valid_q;
  assign credit_out_vc    = credit_out_vc_q;
  assign err              = err_q;

endmodule
